regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Y86-64 register file with decode-side source selection and writeback-side destination
// selection. Reads are combinational with no bypass; writes land on the rising edge.
module regfile_writeback #(
  parameter logic [63:0] STACK_INIT = 64'd1000,
  parameter int unsigned NREG       = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        stall,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val,
  output logic        halted
);

  localparam logic [3:0]  RNone  = 4'hF;
  localparam logic [3:0]  RRsp   = 4'h4;
  localparam int unsigned RspIdx = 4;

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];
  logic        halted_q, halted_d;
  logic [3:0]  src_a, src_b;

  always_comb begin
    unique case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
      4'h9, 4'hB:             src_a = RRsp;
      default:                src_a = RNone;
    endcase

    unique case (icode)
      4'h4, 4'h5, 4'h6:       src_b = rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RRsp;
      default:                src_b = RNone;
    endcase

    unique case (icode)
      4'h3, 4'h6:             dstE = rB;
      4'h2:                   dstE = cnd ? rB : RNone;
      4'h8, 4'h9, 4'hA, 4'hB: dstE = RRsp;
      default:                dstE = RNone;
    endcase

    unique case (icode)
      4'h5, 4'hB: dstM = rA;
      default:    dstM = RNone;
    endcase
  end

  // Index RNONE never matches any register, so it reads as zero.
  always_comb begin
    valA    = '0;
    valB    = '0;
    dbg_val = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (src_a == i[3:0])   valA    = regs_q[i];
      if (src_b == i[3:0])   valB    = regs_q[i];
      if (dbg_sel == i[3:0]) dbg_val = regs_q[i];
    end
  end

  // The valM write is applied after valE so it wins when both target the same register.
  always_comb begin
    regs_d   = regs_q;
    halted_d = halted_q;
    if (!stall && !halted_q) begin
      if (icode == 4'h0) halted_d = 1'b1;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (dstE == i[3:0]) regs_d[i] = valE;
        if (dstM == i[3:0]) regs_d[i] = valM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == RspIdx) ? STACK_INIT : 64'd0;
      end
      halted_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

endmodule
